cis_dvp_capture: RTL and testbench

Parametrised parallel camera (DVP/CIS) capture engine for the ISP user project. It samples the sensor pixel bus, frame sync and line sync on `wb_clk_i` and tracks frame and line state. Captured pixels are buffered in a FIFO that the management SoC drains over the Wishbone slave port. It raises an interrupt on frame completion or overflow. It generalises the fixed 10-bit, single-mode sensor hookup into a configurable capture block.

---
 rtl/cis_dvp_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_cis_dvp_capture.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cis_dvp_capture.sv
// -----------------------------------------------------------------------------
// cis_dvp_capture
// Parallel camera (DVP/CIS) capture engine. Sensor pins are sampled on
// wb_clk_i through 2-FF synchronisers, and a rising edge of the synchronised
// pclk marks a pixel event. Pixels are tagged with start-of-line and
// start-of-frame flags, then buffered in a FIFO. The SoC drains that FIFO
// through a Wishbone classic slave port.
//
// Optional feature: define CIS_CROP_EN to add the CROP_X / CROP_Y window
// registers. Without it, every valid pixel is pushed and those addresses read
// as zero.
// -----------------------------------------------------------------------------
module cis_dvp_capture #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cis_pclk,
  input  logic              cis_vsync,
  input  logic              cis_hsync,
  input  logic [DATA_W-1:0] cis_d,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;  // {sol, sof, data}; valid is implied by occupancy

  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_PIXEL  = 3'd2;
  localparam logic [2:0] A_FCNT   = 3'd3;
  localparam logic [2:0] A_GEOM   = 3'd4;
  localparam logic [2:0] A_CROPX  = 3'd5;
  localparam logic [2:0] A_CROPY  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_FRAME,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and pixel-event stage
  // ---------------------------------------------------------------------------
  logic [1:0]        pclk_sync, vs_sync, hs_sync;
  logic [DATA_W-1:0] d_sync1, d_sync2;
  logic              pclk_s3;

  // Two-flop synchronisers for every sensor pin, plus a third pclk flop for edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      hs_sync   <= '0;
      d_sync1   <= '0;
      d_sync2   <= '0;
      pclk_s3   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each flop one stage apart; blocking would collapse the chain.
      pclk_sync <= {pclk_sync[0], cis_pclk};
      vs_sync   <= {vs_sync[0], cis_vsync};
      hs_sync   <= {hs_sync[0], cis_hsync};
      d_sync1   <= cis_d;
      d_sync2   <= d_sync1;
      pclk_s3   <= pclk_sync[1];
    end
  end

  // Register the pclk edge together with the sync levels, so every event in one cycle refers to the same instant
  logic              evt_q, hs_q, vs_q, hs_p, vs_p;
  logic [DATA_W-1:0] d_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      evt_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hs_p  <= 1'b0;
      vs_p  <= 1'b0;
      d_q   <= '0;
    end else begin
      evt_q <= pclk_sync[1] & ~pclk_s3;
      hs_q  <= hs_sync[1];
      vs_q  <= vs_sync[1];
      hs_p  <= hs_q;
      vs_p  <= vs_q;
      d_q   <= d_sync2;
    end
  end

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  assign hs_rise = hs_q & ~hs_p;
  assign hs_fall = ~hs_q & hs_p;
  assign vs_rise = vs_q & ~vs_p;
  assign vs_fall = ~vs_q & vs_p;

  // ---------------------------------------------------------------------------
  // Wishbone request decode
  // ---------------------------------------------------------------------------
  logic       req, wr_req, rd_req;
  logic [2:0] reg_sel;
  assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;  // one ack per access, even if stb is held
  assign wr_req  = req & wbs_we_i;
  assign rd_req  = req & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];

  // Upper address bits, byte enables other than bit 0, and unused data bits are decoded elsewhere or ignored
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i, wbs_sel_i, wbs_dat_i};

  // ---------------------------------------------------------------------------
  // Control / status state
  // ---------------------------------------------------------------------------
  logic        enable, irq_en, overflow, frame_done;
  logic [31:0] frame_cnt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   flush, in_frame, frame_end, enter_frame;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: clearing enable always wins
  always_comb begin
    // NOTE: assigning a default first guarantees no path leaves state_d unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable)  state_d = S_WAIT_VS;
      S_WAIT_VS: if (vs_fall) state_d = S_FRAME;
      S_FRAME:   if (vs_rise) state_d = S_DONE;
      S_DONE:                 state_d = S_WAIT_VS;
      default:                state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Output decode from the current state and the pending transition
  always_comb begin
    flush       = 1'b0;
    in_frame    = 1'b0;
    frame_end   = 1'b0;
    enter_frame = 1'b0;
    case (state_q)
      S_IDLE:    flush       = 1'b1;
      S_WAIT_VS: enter_frame = (state_d == S_FRAME);
      S_FRAME:   in_frame    = 1'b1;
      S_DONE:    frame_end   = 1'b1;
      default:   flush       = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line / pixel tracking and crop window
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pix_cnt, line_cnt, geom_px, geom_ln;
  logic             sol_pend, sof_pend;
  logic             in_crop;

`ifdef CIS_CROP_EN
  logic [CNT_W-1:0] x_start, x_end, y_start, y_end;

  // Crop window registers; the SoC programs them while capture is stopped or between frames
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      x_start <= '0;
      x_end   <= '0;
      y_start <= '0;
      y_end   <= '0;
    end else if (wr_req && reg_sel == A_CROPX) begin
      x_start <= wbs_dat_i[CNT_W-1:0];
      x_end   <= wbs_dat_i[16+CNT_W-1:16];
    end else if (wr_req && reg_sel == A_CROPY) begin
      y_start <= wbs_dat_i[CNT_W-1:0];
      y_end   <= wbs_dat_i[16+CNT_W-1:16];
    end
  end

  assign in_crop = (pix_cnt >= x_start) && (pix_cnt <= x_end) &&
                   (line_cnt >= y_start) && (line_cnt <= y_end);
`else
  assign in_crop = 1'b1;
`endif

  logic valid_pix, push_try, sol_bit, sof_bit;
  assign valid_pix = in_frame & evt_q & hs_q;
  assign push_try  = valid_pix & in_crop;
  assign sol_bit   = sol_pend | hs_rise;  // covers pclk rising in the same cycle as hsync
  assign sof_bit   = sof_pend;

  // Coordinate counters, SOL/SOF flags and latched geometry
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      geom_px  <= '0;
      geom_ln  <= '0;
      sol_pend <= 1'b0;
      sof_pend <= 1'b0;
    end else if (flush) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      sol_pend <= 1'b0;
      sof_pend <= 1'b0;
    end else if (enter_frame) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      sol_pend <= 1'b0;
      sof_pend <= 1'b1;
    end else if (in_frame) begin
      if (hs_rise) sol_pend <= 1'b1;
      if (valid_pix) pix_cnt <= pix_cnt + CNT_ONE;
      if (push_try) begin
        sol_pend <= 1'b0;
        sof_pend <= 1'b0;
      end
      if (hs_fall) begin
        geom_px  <= pix_cnt;
        pix_cnt  <= '0;
        line_cnt <= line_cnt + CNT_ONE;
      end
    end else if (frame_end) begin
      geom_ln  <= line_cnt;
      line_cnt <= '0;
      pix_cnt  <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, ovf_set;
  logic [EW-1:0] mem_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_req && (reg_sel == A_PIXEL) && !empty;
  assign push    = push_try && (!full || pop);  // a same-cycle pop frees the slot first
  assign ovf_set = push_try && full && !pop;
  assign mem_rd  = mem[rd_ptr[AW-1:0]];

  // Storage array
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the storage array has no reset; occupancy is defined solely by the pointers.
    if (push) mem[wr_ptr[AW-1:0]] <= {sol_bit, sof_bit, d_q};
  end

  // FIFO pointers; leaving enable flushes the contents
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers, interrupt and read path
  // ---------------------------------------------------------------------------
  logic st_w1c;
  assign st_w1c = wr_req && (reg_sel == A_STATUS);

  // CTRL, sticky status bits, frame counter and the registered interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_req && reg_sel == A_CTRL && wbs_sel_i[0]) begin
        enable <= wbs_dat_i[0];
        irq_en <= wbs_dat_i[1];
      end
      // A set event in the same cycle as the W1C clear wins
      overflow   <= (overflow   & ~(st_w1c & wbs_dat_i[2])) | ovf_set;
      frame_done <= (frame_done & ~(st_w1c & wbs_dat_i[3])) | frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 32'd1;
      irq <= irq_en & (overflow | frame_done);
    end
  end

  logic [31:0] rdata;

  // Read-data multiplexer
  always_comb begin
    rdata = '0;
    case (reg_sel)
      A_CTRL:   rdata[1:0] = {irq_en, enable};
      A_STATUS: rdata[3:0] = {frame_done, overflow, full, empty};
      A_PIXEL: begin
        if (!empty) begin
          rdata[31]         = 1'b1;
          rdata[30]         = mem_rd[EW-1];
          rdata[29]         = mem_rd[EW-2];
          rdata[DATA_W-1:0] = mem_rd[DATA_W-1:0];
        end
      end
      A_FCNT:   rdata = frame_cnt;
      A_GEOM:   rdata = {16'(geom_px), 16'(geom_ln)};
`ifdef CIS_CROP_EN
      A_CROPX:  rdata = {16'(x_end), 16'(x_start)};
      A_CROPY:  rdata = {16'(y_end), 16'(y_start)};
`endif
      default:  rdata = '0;
    endcase
  end

  // Single-cycle acknowledge with registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_req ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_cis_dvp_capture.sv
// -----------------------------------------------------------------------------
// tb_cis_dvp_capture
// Directed bench for cis_dvp_capture. Every bus access pushes its expected
// response onto a scoreboard queue. A monitor pops an entry on each ack and
// compares it. Level checks on irq are made inline.
// -----------------------------------------------------------------------------
module tb_cis_dvp_capture;

  localparam int DATA_W     = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 12;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_PIXEL  = 32'h08;
  localparam logic [31:0] A_FCNT   = 32'h0C;
  localparam logic [31:0] A_GEOM   = 32'h10;
  localparam logic [31:0] A_CROPX  = 32'h14;
  localparam logic [31:0] A_CROPY  = 32'h18;
  localparam logic [31:0] A_NONE   = 32'h1C;

  logic              wb_clk_i, wb_rst_i;
  logic              cis_pclk, cis_vsync, cis_hsync;
  logic [DATA_W-1:0] cis_d;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  cis_dvp_capture #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cis_pclk (cis_pclk),
    .cis_vsync(cis_vsync),
    .cis_hsync(cis_hsync),
    .cis_d    (cis_d),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .irq      (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each ack retires the oldest outstanding access
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with no outstanding access at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_read) check(e.name, wbs_dat_o, e.exp);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // One Wishbone classic access; starts and ends just after a rising edge
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string name);
    exp_t e;
    bit   got;
    e.is_read = !we;
    e.exp     = exp;
    e.name    = name;
    exp_q.push_back(e);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) got = 1'b1;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no ack, expected ack within 8 cycles", name);
      exp_q.delete(exp_q.size() - 1);
    end
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, exp, name);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input string name);
    wb_xfer(1'b1, adr, dat, 4'hF, 32'h0, name);
  endtask

  // Sensor side: pclk half period is 4 wb_clk cycles
  task automatic pixel(input logic [DATA_W-1:0] d);
    cis_d = d;
    wait_clk(4);
    cis_pclk = 1'b1;
    wait_clk(4);
    cis_pclk = 1'b0;
  endtask

  task automatic line_begin();
    cis_hsync = 1'b1;
    wait_clk(4);
  endtask

  task automatic line_end();
    cis_hsync = 1'b0;
    wait_clk(6);
  endtask

  task automatic frame_begin();
    cis_vsync = 1'b0;
    wait_clk(6);
  endtask

  task automatic frame_end();
    cis_vsync = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp;
    wb_rst_i  = 1'b1;
    cis_pclk  = 1'b0;
    cis_vsync = 1'b1;
    cis_hsync = 1'b0;
    cis_d     = '0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wait_clk(4);
    wb_rst_i = 1'b0;
    wait_clk(2);

    // Reset state
    check("irq_reset", {31'b0, irq}, 32'h0);
    rd(A_CTRL,   32'h0, "ctrl_reset");
    rd(A_STATUS, 32'h1, "status_reset");
    rd(A_PIXEL,  32'h0, "pixel_reset");
    rd(A_FCNT,   32'h0, "fcnt_reset");
    rd(A_GEOM,   32'h0, "geom_reset");
    rd(A_CROPX,  32'h0, "cropx_reset");
    rd(A_CROPY,  32'h0, "cropy_reset");
    rd(A_NONE,   32'h0, "unmapped_read");
    wr(A_FCNT, 32'hFFFF_FFFF, "fcnt_write");
    rd(A_FCNT, 32'h0, "fcnt_ro");
    wb_xfer(1'b1, A_CTRL, 32'h3, 4'h0, 32'h0, "ctrl_sel0_write");
    rd(A_CTRL, 32'h0, "ctrl_sel0_ignored");
    wr(A_CTRL, 32'h3, "ctrl_enable");
    rd(A_CTRL, 32'h3, "ctrl_readback");
    wait_clk(2);

    // 2-line x 4-pixel frame
    frame_begin();
    line_begin();
    pixel(10'h3FF);
    for (int i = 1; i < 4; i++) pixel(10'(i));
    line_end();
    line_begin();
    for (int i = 4; i < 8; i++) pixel(10'(i));
    line_end();
    frame_end();
    check("irq_frame_done", {31'b0, irq}, 32'h1);
    rd(A_STATUS, 32'h8, "status_frame");
    rd(A_FCNT, 32'h1, "fcnt_frame1");
    rd(A_GEOM, 32'h0004_0002, "geom_2x4");
    for (int i = 0; i < 8; i++) begin
      exp = 32'h8000_0000 | 32'(i);
      if (i == 0) exp = 32'hE000_03FF;
      if (i == 4) exp = exp | 32'h4000_0000;
      rd(A_PIXEL, exp, "pixel_2x4");
    end
    rd(A_PIXEL, 32'h0, "pixel_empty_after_drain");
    rd(A_STATUS, 32'h9, "status_drained");
    wr(A_STATUS, 32'h8, "clear_frame_done");
    check("irq_clear_lag", {31'b0, irq}, 32'h1);
    wait_clk(1);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // 20-pixel line, no reads: overflow
    frame_begin();
    line_begin();
    for (int i = 0; i < 20; i++) pixel(10'(32'h100 + i));
    line_end();
    frame_end();
    rd(A_STATUS, 32'hE, "status_overflow");
    check("irq_overflow", {31'b0, irq}, 32'h1);
    rd(A_GEOM, 32'h0014_0001, "geom_20x1");
    rd(A_FCNT, 32'h2, "fcnt_frame2");
    wr(A_STATUS, 32'h8, "clear_fd_only");
    wait_clk(2);
    check("irq_overflow_held", {31'b0, irq}, 32'h1);
    wr(A_STATUS, 32'h4, "clear_overflow");
    check("irq_ovf_clear_lag", {31'b0, irq}, 32'h1);
    wait_clk(1);
    check("irq_ovf_cleared", {31'b0, irq}, 32'h0);
    rd(A_STATUS, 32'h2, "status_full_no_ovf");

    // Pixel push lands on the same edge as a PIXEL pop while full
    frame_begin();
    line_begin();
    cis_d    = 10'h2AA;
    cis_pclk = 1'b1;
    wait_clk(3);
    rd(A_PIXEL, 32'hE000_0100, "pop_while_full");
    wait_clk(2);
    cis_pclk = 1'b0;
    wait_clk(4);
    line_end();
    frame_end();
    rd(A_STATUS, 32'hA, "no_ovf_on_pop_push");
    for (int i = 1; i < 16; i++) rd(A_PIXEL, 32'h8000_0100 | 32'(i), "drain_full");
    rd(A_PIXEL, 32'hE000_02AA, "pixel_pushed_on_pop");
    rd(A_PIXEL, 32'h0, "pixel_empty_after_full");
    rd(A_GEOM, 32'h0001_0001, "geom_1x1");
    rd(A_FCNT, 32'h3, "fcnt_frame3");

    // Disable mid-line, re-enable with vsync already low
    wr(A_STATUS, 32'hC, "clear_all");
    frame_begin();
    line_begin();
    pixel(10'h001);
    pixel(10'h002);
    wr(A_CTRL, 32'h2, "disable_midline");
    pixel(10'h003);
    line_end();
    wr(A_CTRL, 32'h3, "reenable");
    wait_clk(2);
    line_begin();
    pixel(10'h004);
    pixel(10'h005);
    line_end();
    rd(A_STATUS, 32'h1, "status_no_push_midframe");
    rd(A_PIXEL, 32'h0, "pixel_none_midframe");
    rd(A_FCNT, 32'h3, "fcnt_retained");
    frame_end();
    frame_begin();
    line_begin();
    pixel(10'h055);
    line_end();
    frame_end();
    rd(A_PIXEL, 32'hE000_0055, "pixel_after_resync");
    rd(A_FCNT, 32'h4, "fcnt_frame4");

`ifdef CIS_CROP_EN
    // Crop window x=1..2, y=1 on a 4x3 frame
    wr(A_STATUS, 32'hC, "clear_all_crop");
    wr(A_CROPX, 32'h0002_0001, "cropx_write");
    wr(A_CROPY, 32'h0001_0001, "cropy_write");
    rd(A_CROPX, 32'h0002_0001, "cropx_readback");
    rd(A_CROPY, 32'h0001_0001, "cropy_readback");
    frame_begin();
    for (int l = 0; l < 3; l++) begin
      line_begin();
      for (int x = 0; x < 4; x++) pixel(10'(16 * l + x));
      line_end();
    end
    frame_end();
    rd(A_PIXEL, 32'hE000_0011, "crop_first");
    rd(A_PIXEL, 32'h8000_0012, "crop_second");
    rd(A_PIXEL, 32'h0, "crop_empty");
    rd(A_GEOM, 32'h0004_0003, "geom_uncropped");
`else
    wr(A_CROPX, 32'hFFFF_FFFF, "cropx_write_ignored");
    wr(A_CROPY, 32'hFFFF_FFFF, "cropy_write_ignored");
    rd(A_CROPX, 32'h0, "cropx_absent");
    rd(A_CROPY, 32'h0, "cropy_absent");
`endif

    wait_clk(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
